// File: rtl/bar_level_reader_pkg.sv
// Shared types and helpers for the switch bar-graph reader.
// Holds the FSM encoding, the bin midpoint and the thermometer decode.
package bar_level_reader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    REPORT = 2'd2
  } state_e;

  localparam logic [4:0] BIN_MID = 5'b10000;

  typedef struct packed {
    logic       legal;
    logic [2:0] level;
  } decode_t;

  // A legal bar is 2^n-1 for n in 1..8: bit0 set and v+1 is a power of two (or wraps to 0).
  function automatic decode_t thermo_decode(input logic [7:0] v);
    decode_t    d;
    logic [3:0] ones;
    logic [7:0] v_plus1;
    ones = '0;
    for (int i = 0; i < 8; i++) begin
      ones = ones + {3'b000, v[i]};
    end
    v_plus1 = v + 8'd1;
    d.legal = v[0] && ((v & v_plus1) == 8'h00);
    d.level = d.legal ? 3'(ones - 4'd1) : 3'd0;
    return d;
  endfunction

endpackage

// File: rtl/bar_level_reader_vec.sv
// Two-flop synchronizer plus whole-vector debouncer.
// A vector is accepted once the synchronized value has held for DB_LIMIT cycles.
module vec_debounce #(
  parameter int DB_LIMIT = 50000,
  parameter int DB_W     = 16,
  parameter int W        = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_vec,
  output logic [W-1:0] o_stable
);

  logic [W-1:0]    r_s1;
  logic [W-1:0]    r_s2;
  logic [W-1:0]    r_cand;
  logic [DB_W-1:0] r_cnt;
  logic [W-1:0]    r_stable;

  localparam logic [DB_W-1:0] CNT_TOP = DB_W'(DB_LIMIT - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_cand   <= '0;
      r_cnt    <= '0;
      r_stable <= '0;
    end else begin
      r_s1 <= i_vec;
      r_s2 <= r_s1;
      // Any change restarts the hold window, so short glitches never land.
      if (r_s2 != r_cand) begin
        r_cand <= r_s2;
        r_cnt  <= '0;
      end else if (r_cnt == CNT_TOP) begin
        r_stable <= r_cand;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/bar_level_reader.sv
// Switch bar-graph reader: debounced thermometer input decoded to a level
// and scaled value, offered on a valid/ready report interface.
module bar_level_reader
  import bar_level_reader_pkg::*;
#(
  parameter int DB_LIMIT = 50000,
  parameter int DB_W     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [2:0] level_out,
  output logic [7:0] value_out,
  output logic       out_err,
  output state_e     o_dbg_state
);

  logic [7:0] w_stable;
  logic [7:0] r_last;
  state_e     r_state;
  state_e     w_state_nxt;
  decode_t    w_dec;

  logic       r_valid;
  logic [2:0] r_level;
  logic [7:0] r_value;
  logic       r_err;

  vec_debounce #(
    .DB_LIMIT (DB_LIMIT),
    .DB_W     (DB_W),
    .W        (8)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .i_vec    (sw),
    .o_stable (w_stable)
  );

  assign w_dec = thermo_decode(r_last);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_stable != r_last) w_state_nxt = DECODE;
      DECODE:  w_state_nxt = REPORT;
      REPORT:  if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshake: a report transfers on any edge where out_valid && out_ready;
  // out_valid and the payload stay frozen until then, and out_ready is
  // ignored while out_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last  <= '0;
      r_valid <= 1'b0;
      r_level <= '0;
      r_value <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == IDLE && w_stable != r_last) begin
        r_last <= w_stable;
      end
      if (r_state == DECODE) begin
        r_valid <= 1'b1;
        r_level <= w_dec.level;
        r_value <= w_dec.legal ? {w_dec.level, BIN_MID} : 8'h00;
        r_err   <= ~w_dec.legal;
      end
      if (r_state == REPORT && out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = r_valid;
  assign level_out   = r_level;
  assign value_out   = r_value;
  assign out_err     = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bar_level_reader.sv
// Directed bench for bar_level_reader with a short debounce window.
module tb_bar_level_reader;
  import bar_level_reader_pkg::*;

  localparam int DB_LIMIT = 4;

  logic       clk;
  logic       rst;
  logic [7:0] sw;
  logic       out_ready;
  logic       out_valid;
  logic [2:0] level_out;
  logic [7:0] value_out;
  logic       out_err;
  state_e     dbg_state;

  int checks   = 0;
  int failures = 0;
  int xfers    = 0;
  logic [2:0] got_q[$];

  bar_level_reader #(.DB_LIMIT(DB_LIMIT), .DB_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .sw          (sw),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .level_out   (level_out),
    .value_out   (value_out),
    .out_err     (out_err),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle; inputs are driven 1 time unit after the edge and a pending
  // transfer is logged just before the edge that performs it.
  task automatic tick();
    if (out_valid && out_ready) begin
      xfers++;
      got_q.push_back(level_out);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_valid(input int budget, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (out_valid) begin
        ok = 1'b1;
        n  = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit seen;
    rst = 1'b1; sw = 8'h00; out_ready = 1'b0;
    ticks(3);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b want 0", seen); end
    checks++;
    if (level_out !== 3'd0) begin failures++; $display("FAIL reset_level: got %0d want 0", level_out); end
    checks++;
    if (value_out !== 8'h00) begin failures++; $display("FAIL reset_value: got %h want 00", value_out); end
    checks++;
    if (out_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %0b want 0", out_err); end
    checks++;
    if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
  endtask

  task automatic test_level2();
    int n; bit ok;
    out_ready = 1'b1;
    sw = 8'b0000_0111;
    wait_valid(30, n, ok);
    // n counts edges after the drive; the first of them is where sw is first sampled.
    checks++;
    if (!ok || (n - 1) !== DB_LIMIT + 4) begin
      failures++; $display("FAIL l2_latency: got %0d (ok=%0b) want %0d", n - 1, ok, DB_LIMIT + 4);
    end
    checks++;
    if (level_out !== 3'd2) begin failures++; $display("FAIL l2_level: got %0d want 2", level_out); end
    checks++;
    if (value_out !== 8'h50) begin failures++; $display("FAIL l2_value: got %h want 50", value_out); end
    checks++;
    if (out_err !== 1'b0) begin failures++; $display("FAIL l2_err: got %0b want 0", out_err); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL l2_one_cycle: got %0b want 0", out_valid); end
  endtask

  task automatic test_hold();
    int n; bit ok; bit bad; int x0;
    out_ready = 1'b0;
    sw = 8'hFF;
    wait_valid(30, n, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL hold_timeout: got no valid within 30 want valid"); end
    x0  = xfers;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b1 || level_out !== 3'd7 || value_out !== 8'hF0 || out_err !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL hold_frozen: got v=%0b l=%0d val=%h want v=1 l=7 val=f0", out_valid, level_out, value_out);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL hold_release: got %0b want 0", out_valid); end
    ticks(15);
    checks++;
    if (xfers - x0 !== 1) begin failures++; $display("FAIL hold_single: got %0d transfers want 1", xfers - x0); end
  endtask

  task automatic test_illegal();
    int n; bit ok;
    out_ready = 1'b1;
    sw = 8'b0000_0101;
    wait_valid(30, n, ok);
    checks++;
    if (!ok || out_err !== 1'b1) begin failures++; $display("FAIL bad_err: got %0b (ok=%0b) want 1", out_err, ok); end
    checks++;
    if (level_out !== 3'd0) begin failures++; $display("FAIL bad_level: got %0d want 0", level_out); end
    checks++;
    if (value_out !== 8'h00) begin failures++; $display("FAIL bad_value: got %h want 00", value_out); end
    ticks(3);
  endtask

  task automatic test_glitch();
    int x0;
    out_ready = 1'b1;
    ticks(5);
    x0 = xfers;
    got_q.delete();
    for (int i = 0; i < 5; i++) begin
      sw = 8'b0000_0001; ticks(2);
      sw = 8'b0000_0011; ticks(2);
    end
    ticks(30);
    checks++;
    if (xfers - x0 !== 1) begin failures++; $display("FAIL glitch_count: got %0d reports want 1", xfers - x0); end
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 3'd1) begin
      failures++; $display("FAIL glitch_level: got size=%0d want one level 1", got_q.size());
    end
    checks++;
    if (value_out !== 8'h30) begin failures++; $display("FAIL glitch_value: got %h want 30", value_out); end
  endtask

  task automatic test_back_to_back();
    int n; bit ok; bit bad;
    out_ready = 1'b0;
    got_q.delete();
    sw = 8'b0000_0111;
    wait_valid(30, n, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL b2b_first: got no valid within 30 want valid"); end
    bad = 1'b0;
    sw = 8'b0000_1111;
    for (int i = 0; i < 8; i++) begin tick(); if (level_out !== 3'd2 || out_valid !== 1'b1) bad = 1'b1; end
    sw = 8'b0001_1111;
    for (int i = 0; i < 10; i++) begin tick(); if (level_out !== 3'd2 || out_valid !== 1'b1) bad = 1'b1; end
    checks++;
    if (bad) begin failures++; $display("FAIL b2b_frozen: got l=%0d v=%0b want l=2 v=1", level_out, out_valid); end
    out_ready = 1'b1;
    wait_valid(10, n, ok);
    checks++;
    if (!ok || n !== 3) begin failures++; $display("FAIL b2b_spacing: got %0d (ok=%0b) want 3", n, ok); end
    checks++;
    if (level_out !== 3'd4) begin failures++; $display("FAIL b2b_level: got %0d want 4", level_out); end
    checks++;
    if (value_out !== 8'h90) begin failures++; $display("FAIL b2b_value: got %h want 90", value_out); end
    ticks(10);
    checks++;
    if (got_q.size() != 2 || got_q[0] !== 3'd2 || got_q[1] !== 3'd4) begin
      failures++; $display("FAIL b2b_sequence: got %0d reports want levels 2 then 4", got_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int n; bit ok;
    out_ready = 1'b0;
    sw = 8'b0011_1111;
    wait_valid(30, n, ok);
    checks++;
    if (!ok || level_out !== 3'd5) begin failures++; $display("FAIL rmid_pre: got l=%0d (ok=%0b) want 5", level_out, ok); end
    rst = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid: got %0b want 0", out_valid); end
    checks++;
    if (level_out !== 3'd0 || dbg_state !== IDLE) begin
      failures++; $display("FAIL rmid_clear: got l=%0d st=%0d want 0 0", level_out, dbg_state);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    wait_valid(30, n, ok);
    checks++;
    if (!ok || level_out !== 3'd5 || value_out !== 8'hB0) begin
      failures++; $display("FAIL rmid_after: got l=%0d val=%h (ok=%0b) want 5 b0", level_out, value_out, ok);
    end
  endtask

  initial begin
    rst = 1'b1; sw = 8'h00; out_ready = 1'b0;
    test_reset();
    test_level2();
    test_hold();
    test_illegal();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bar_level_reader.md
# bar_level_reader

Input-side counterpart of the LED bar-graph driver. It samples an 8-bit thermometer-coded bar from the board switches, debounces it as a whole vector, and validates the code. Each new stable bar is decoded to a 3-bit level and an 8-bit scaled value, which is presented on a valid/ready handshake. It sits between the switch pins and whatever logic consumes a level setting, so a bar entered on the switches round-trips through the bar-graph LED driver.

## Interface
- DB_LIMIT, 50000: consecutive cycles the synchronized vector must hold before it is accepted (≥2).
- DB_W, 16: width of the debounce counter; must hold DB_LIMIT-1.
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- sw  in  8  raw switch vector, asynchronous to clk.
- out_ready  in  1  consumer accepts the current report.
- out_valid  out  1  report pending; held until accepted.
- level_out  out  3  decoded level 0..7.
- value_out  out  8  scaled value {level_out, 5'b10000}, the midpoint of the level's 32-wide bin.
- out_err  out  1  reported vector was not a legal bar code.

## Operation
- Synchronizer: 2-flop on sw → sw_s.
- Debounce, whole vector:
  - cand register and counter cnt.
  - If sw_s ≠ cand: cand ← sw_s, cnt ← 0.
  - Else if cnt = DB_LIMIT-1: stable ← cand, cnt holds.
  - Else cnt+1.
- Legal code: 8'b0000_0001, 0000_0011, … 1111_1111, i.e. bit0 set and no 0 below a 1.
  - Level = (number of ones) − 1.
- Illegal code, including 8'h00: level_out = 0, value_out = 0, out_err = 1.
- FSM states IDLE, DECODE, REPORT:
  - IDLE → DECODE when stable ≠ last; last ← stable.
  - DECODE → REPORT: level_out, value_out and out_err are registered from last; out_valid ← 1.
  - REPORT → IDLE when out_ready = 1; out_valid ← 0 in the same edge.
  - REPORT holds while out_ready = 0; outputs stay frozen.
- The debouncer keeps running in REPORT. If stable changes during REPORT, only the newest value is reported after the handshake; intermediate values are dropped.
- If stable returns to last before IDLE is re-entered, no report is made.
- Reset values:
  - Outputs: out_valid 0, level_out 0, value_out 0, out_err 0.
  - Internal: sync flops 0, cand 0, cnt 0, stable 0, last 0, state IDLE.
  - Consequence: all-zero switches after reset produce no report.
- rst mid-report: out_valid drops on that edge and the pending report is lost. After reset the current switch vector is reported once it is stable, if nonzero.

## Timing
- Pin change (held steady) to out_valid rise: DB_LIMIT + 4 cycles.
  - 2 sync + DB_LIMIT debounce + 1 IDLE→DECODE + 1 DECODE→REPORT.
- Handshake: the transfer occurs on an edge where out_valid & out_ready.
  - out_valid is low for at least one cycle (IDLE) between reports.
  - Minimum spacing between reports: 3 cycles.
- out_ready may be high while out_valid is low; it is ignored in that case.
- Glitch rejection: any sw_s change restarts cnt, so pulses shorter than DB_LIMIT cycles never reach stable.

## Structure
- Shared package/header holds:
  - FSM state encodings (IDLE=2'd0, DECODE=2'd1, REPORT=2'd2).
  - Constant BIN_MID = 5'b10000.
  - Decode function: thermometer → {legal, level}.
- Sub-module vec_debounce, parameterized by DB_LIMIT, DB_W and vector width 8, contains sync + cand + cnt + stable.
- The top module holds last, the FSM and the output registers.

## Test plan
All scenarios use DB_LIMIT=4.
- Reset with sw=8'h00, run 20 cycles → out_valid stays 0; all outputs 0.
- sw=8'b0000_0111, out_ready=1 → out_valid high exactly 8 cycles after the change, for 1 cycle; level_out=2, value_out=8'h50, out_err=0.
- sw=8'hFF with out_ready=0 for 10 cycles, then 1 → level_out=7, value_out=8'hF0 held the whole time; single transfer.
- sw=8'b0000_0101 → out_err=1, level_out=0, value_out=0.
- sw toggles 0000_0001↔0000_0011 every 2 cycles for 20 cycles, then settles at 0000_0011 → exactly one report, level_out=1, value_out=8'h30.
- During REPORT (ready low), sw goes 0000_1111 then 0001_1111 (each stable ≥4 cycles), then ready=1:
  - Second report is level_out=4, value_out=8'h90; level 3 is never reported.
  - rst asserted during a later REPORT → out_valid=0 next cycle.
